regfile_wb: RTL
===============

# regfile_wb

Write-back stage and architectural register file for the CPU54 core. It consumes the ALU result and status flags, commits them to the 32×32 general-purpose register file, and raises a precise overflow exception for trapping add/sub instructions. It also supplies the two ALU source operands through combinational read ports, and holds HI/LO plus a latched copy of the ALU flags.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating overflow-event counter.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ra_addr`  in  5  read port A address; feeds ALU operand a.
- `rb_addr`  in  5  read port B address; feeds ALU operand b.
- `ra_data`  out  32  read port A data, combinational.
- `rb_data`  out  32  read port B data, combinational.
- `wb_en`  in  1  write-back request for the current instruction.
- `wb_addr`  in  5  destination register.
- `wb_data`  in  32  ALU result r.
- `ovf_trap`  in  1  current instruction traps on overflow (ADD, ADDI, SUB).
- `alu_zero`, `alu_carry`, `alu_negative`, `alu_overflow`  in  1 each  ALU status flags.
- `flags_we`  in  1  latch the ALU flags this cycle.
- `flags`  out  4  latched flags {overflow, negative, carry, zero}.
- `hi_we`, `lo_we`  in  1 each  HI/LO write enables.
- `hi_wdata`, `lo_wdata`  in  32 each  HI/LO write data.
- `hi`, `lo`  out  32 each  HI/LO contents.
- `exc_ovf`  out  1  one-cycle overflow exception pulse.
- `ovf_count`  out  CNT_W  saturating count of trapped overflows.

## Operation
- Trap condition: `trap = wb_en & ovf_trap & alu_overflow`.
- Effective write: `we_eff = wb_en & ~trap & (wb_addr != 0)`.
- On a rising edge with `we_eff`, `wb_data` is written to `reg[wb_addr]`.
- Register 0 is never written, and `ra_data`/`rb_data` return 0 whenever the port address is 0.
- Read bypass: if `we_eff` is high and a read address equals `wb_addr`, that port returns `wb_data` in the same cycle. Otherwise it returns the array contents. Both ports bypass independently.
- A trapped instruction leaves the register file unchanged. On the next edge, `exc_ovf` is set to 1 for exactly one cycle and `ovf_count` increments. The counter saturates at all-ones and does not wrap.
- `flags_we` captures {`alu_overflow`, `alu_negative`, `alu_carry`, `alu_zero`} independently of `wb_en`. It still captures on a trapped instruction.
- `hi_we` and `lo_we` are independent; each register updates only on its own enable. They may be written in the same cycle as a GPR write.
- Simultaneous write to the same GPR from back-to-back cycles: the last edge wins. There is no write-port conflict, since only one write port exists.

## Timing
- Reset (asynchronous, immediate) clears all 32 GPRs, `hi`, `lo`, `flags`, `exc_ovf` and `ovf_count` to 0.
- While `rst` is high, all writes are ignored. Read ports return 0 for every address, and no bypass occurs.
- Reset released mid-instruction: the first edge after deassertion behaves as a normal cycle.
- Read latency is 0 cycles (combinational). Write latency is 1 edge, so a non-bypassed read sees the new value the cycle after the write.
- `exc_ovf` is registered: it rises 1 cycle after the trapping instruction's cycle and falls on the following edge unless a new trap occurs. Back-to-back traps hold `exc_ovf` high continuously, and the count increments on each.
- `hi`, `lo` and `flags` outputs are registered and have no bypass. The written value is visible the cycle after the enable.

## Test plan
- Reset/zero: write 0xDEADBEEF to r0 and 0x12345678 to r5, then read both. r0 must read 0 and r5 must read 0x12345678. Then assert `rst` asynchronously mid-cycle; `ra_data` for r5 must read 0 immediately.
- Bypass: in the same cycle, write 0xA5A5A5A5 to r7 with `ra_addr = rb_addr = 7`. Both ports must show 0xA5A5A5A5 that cycle. With `wb_en` low, the ports must show the old value.
- Overflow trap: `wb_en = 1`, `ovf_trap = 1`, `alu_overflow = 1`, `wb_addr = 3`, `wb_data = 0x80000000`. r3 must stay unchanged, `exc_ovf` must pulse high one cycle later for exactly one cycle, and `ovf_count` must read 1. The same stimulus with `ovf_trap = 0` (ADDU) must write r3 with no exception.
- Counter saturation with `CNT_W = 2`: five consecutive traps must give `ovf_count` 1, 2, 3, 3, 3, and `exc_ovf` must stay high for five cycles.
- Flags: `flags_we` with carry = 1 and zero = 1 must give `flags = 4'b0011` on the next cycle. `flags` must then hold while `flags_we` is low, even as the ALU flags change.
- HI/LO: `hi_we` only, with `hi_wdata = 0x1` and `lo_wdata = 0x2`, must give `hi = 1` and `lo = 0`. Both enables together must then update both registers in one edge.

Source files
------------

// File: rtl/regfile_wb.sv
// Write-back stage for CPU54: 32x32 GPR file with bypassed read ports,
// HI/LO, latched ALU flags and a precise overflow trap with event counter.
module regfile_wb #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ra_addr,
  input  logic [4:0]       rb_addr,
  output logic [31:0]      ra_data,
  output logic [31:0]      rb_data,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  input  logic             ovf_trap,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_negative,
  input  logic             alu_overflow,
  input  logic             flags_we,
  output logic [3:0]       flags,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [31:0]      hi_wdata,
  input  logic [31:0]      lo_wdata,
  output logic [31:0]      hi,
  output logic [31:0]      lo,
  output logic             exc_ovf,
  output logic [CNT_W-1:0] ovf_count
);

  logic [31:0]      gpr_q [32];
  logic [31:0]      hi_q, lo_q;
  logic [3:0]       flags_q;
  logic             exc_ovf_q;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
  logic             trap, we_eff;

  always_comb begin
    trap   = wb_en & ovf_trap & alu_overflow;
    we_eff = wb_en & ~trap & (wb_addr != 5'd0);
  end

  // Reads are forced to zero during reset so nothing leaks out, bypass included.
  always_comb begin
    ra_data = '0;
    rb_data = '0;
    if (!rst) begin
      if (ra_addr != 5'd0)
        ra_data = (we_eff && ra_addr == wb_addr) ? wb_data : gpr_q[ra_addr];
      if (rb_addr != 5'd0)
        rb_data = (we_eff && rb_addr == wb_addr) ? wb_data : gpr_q[rb_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (we_eff) begin
      gpr_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (trap && (ovf_count_q != {CNT_W{1'b1}}))
      ovf_count_d = ovf_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q        <= '0;
      lo_q        <= '0;
      flags_q     <= '0;
      exc_ovf_q   <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      if (hi_we)    hi_q    <= hi_wdata;
      if (lo_we)    lo_q    <= lo_wdata;
      if (flags_we) flags_q <= {alu_overflow, alu_negative, alu_carry, alu_zero};
      exc_ovf_q   <= trap;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign flags     = flags_q;
  assign exc_ovf   = exc_ovf_q;
  assign ovf_count = ovf_count_q;

endmodule
